// File: rtl/vend_pkg.sv
// Shared types for the vending discount engine: sell FSM encoding and its Moore output.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        DISPENSE = 2'd2,
        COOL     = 2'd3
    } state_e;

    function automatic logic sell_of(input state_e s);
        case (s)
            IDLE, ARMED: return 1'b1;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vend_discount_engine_lane.sv
// One discount lane: unsigned add, wrapping by default or saturating when
// VEND_DISCOUNT_SAT_EN is defined.
module vend_lane_adder #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic                  sat_o
);

`ifdef VEND_DISCOUNT_SAT_EN
    logic [DATA_WIDTH:0] full;

    assign full  = {1'b0, a_i} + {1'b0, b_i};
    assign sat_o = full[DATA_WIDTH];
    assign sum_o = full[DATA_WIDTH] ? '1 : full[DATA_WIDTH-1:0];
`else
    assign sum_o = a_i + b_i;
    assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/vend_discount_engine.sv
// Lane-wise discount adder behind a valid/ready register, with a 4-state sell FSM
// stepped once per accepted transaction. Saturation selected by VEND_DISCOUNT_SAT_EN.
//
// state    | meaning
// IDLE     | waiting for a sale, sell=1
// ARMED    | sale armed, sell=1
// DISPENSE | dispensing, sell=0
// COOL     | cool-down after dispense, sell=0
module vend_discount_engine
    import vend_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int K          = 16,
    parameter int NUM_SRC    = 4,
    parameter int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          condition,
    input  logic [SEL_W-1:0]              sel_a,
    input  logic [SEL_W-1:0]              sel_b,
    input  logic [NUM_SRC*K*DATA_WIDTH-1:0] discounts,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [K*DATA_WIDTH-1:0]       total_discount,
    output logic                          out_sell,
    output logic [K-1:0]                  out_sat,
    output logic                          sell_signal,
    output logic [CNT_W-1:0]              sale_count
);

    localparam int VW = K * DATA_WIDTH;

    state_e            state_q, state_d;
    logic              out_valid_q;
    logic [VW-1:0]     total_q, total_d;
    logic              out_sell_q;
    logic [K-1:0]      out_sat_q, sat_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              acc;

    logic [DATA_WIDTH-1:0] src [NUM_SRC][K];

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        for (genvar l = 0; l < K; l++) begin : g_lane
            assign src[s][l] = discounts[(s*K + l)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Out-of-range source indices contribute a zero operand.
    for (genvar l = 0; l < K; l++) begin : g_add
        logic [DATA_WIDTH-1:0] op_a, op_b;

        assign op_a = (int'(sel_a) < NUM_SRC) ? src[sel_a][l] : '0;
        assign op_b = (int'(sel_b) < NUM_SRC) ? src[sel_b][l] : '0;

        vend_lane_adder #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .a_i   (op_a),
            .b_i   (op_b),
            .sum_o (total_d[l*DATA_WIDTH +: DATA_WIDTH]),
            .sat_o (sat_d[l])
        );
    end

    assign in_ready    = !out_valid_q || out_ready;
    assign acc         = in_valid && in_ready;
    assign sell_signal = sell_of(state_q);

    always_comb begin
        state_d = state_q;
        if (acc) begin
            case (state_q)
                IDLE:     state_d = condition ? DISPENSE : ARMED;
                ARMED:    state_d = condition ? COOL     : IDLE;
                DISPENSE: state_d = condition ? DISPENSE : COOL;
                COOL:     state_d = condition ? IDLE     : DISPENSE;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            total_q     <= '0;
            out_sell_q  <= 1'b0;
            out_sat_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                total_q     <= total_d;
                out_sat_q   <= sat_d;
                out_sell_q  <= sell_signal;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (acc && sell_signal) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign total_discount = total_q;
    assign out_sell       = out_sell_q;
    assign out_sat        = out_sat_q;
    assign sale_count     = cnt_q;

endmodule
